// File: rtl/sprite_anim_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sprite_anim_ctrl_pkg
// Shared encodings and constants for the player sprite animation path.
//   - anim_sel / FSM state encodings (STAND, RUN, JUMP, HURT)
//   - player_state and game_state input encodings
//   - sprite geometry and FRAME_WORDS (ROM words per animation frame)
//   - TRANSPARENT colour key, reused by the image renderer
//   - anim_request(): maps a raw player_state onto the animation it selects
// ---------------------------------------------------------------------------
package sprite_anim_ctrl_pkg;

    // Animation / FSM state encodings, identical to the anim_sel output code
    localparam logic [1:0] ANIM_STAND = 2'd0;
    localparam logic [1:0] ANIM_RUN   = 2'd1;
    localparam logic [1:0] ANIM_JUMP  = 2'd2;
    localparam logic [1:0] ANIM_HURT  = 2'd3;

    // player_state input encodings
    localparam logic [3:0] PS_STAND = 4'd0;
    localparam logic [3:0] PS_RUN   = 4'd1;
    localparam logic [3:0] PS_JUMP  = 4'd2;
    localparam logic [3:0] PS_HURT  = 4'd3;

    // game_state input encodings; anything else is treated as inactive
    localparam logic [3:0] GS_PLAY  = 4'd1;
    localparam logic [3:0] GS_PAUSE = 4'd2;

    // Default sprite geometry and the resulting ROM stride per frame
    localparam int         PLAYER_SIZE_X_DEF = 37;
    localparam int         PLAYER_SIZE_Y_DEF = 42;
    localparam logic [15:0] FRAME_WORDS      = 16'(PLAYER_SIZE_X_DEF * PLAYER_SIZE_Y_DEF);

    // Colour key the renderer treats as see-through
    localparam logic [23:0] TRANSPARENT = 24'hFF0096;

    // Divider counter width: holds tick counts up to 63
    localparam int DIV_W = 6;

    // Unknown player states fall back to the standing animation
    function automatic logic [1:0] anim_request(input logic [3:0] ps);
        logic [1:0] sel;
        case (ps)
            PS_STAND: sel = ANIM_STAND;
            PS_RUN:   sel = ANIM_RUN;
            PS_JUMP:  sel = ANIM_JUMP;
            PS_HURT:  sel = ANIM_HURT;
            default:  sel = ANIM_STAND;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/sprite_anim_ctrl_anim_frame_counter.sv
// ---------------------------------------------------------------------------
// anim_frame_counter
// Tick divider plus frame counter for one animation sequence.
//   VGA_clk, rst   : clock, asynchronous active-high reset
//   tick           : advance request (already qualified by the caller)
//   restart        : return to frame 0, divider 0, done 0 (wins over tick)
//   div            : ticks per frame; compared against the running divider
//                    every tick, so a shorter div takes effect immediately
//   n_frames       : frames in the sequence (1..8)
//   saturate       : 1 = stop on the last frame and raise done, 0 = wrap
//   frame          : registered frame index
//   frame_nxt      : value frame takes at the next edge (lets the parent
//                    register derived values in step with frame)
//   done           : registered, high while saturated on the last frame
// ---------------------------------------------------------------------------
module anim_frame_counter
    import sprite_anim_ctrl_pkg::*;
(
    input  logic             VGA_clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             restart,
    input  logic [DIV_W-1:0] div,
    input  logic [3:0]       n_frames,
    input  logic             saturate,
    output logic [2:0]       frame,
    output logic [2:0]       frame_nxt,
    output logic             done
);

    logic [DIV_W-1:0] div_cnt_r;
    logic [DIV_W-1:0] div_nxt_s;
    logic [2:0]       frame_r;
    logic             done_r;
    logic             done_nxt_s;
    logic [3:0]       last_frame_s;
    logic             at_last_s;

    // Next-state logic for divider, frame and done flag
    always_comb begin
        frame_nxt    = frame_r;
        div_nxt_s    = div_cnt_r;
        done_nxt_s   = done_r;
        last_frame_s = n_frames - 4'd1;
        at_last_s    = ({1'b0, frame_r} >= last_frame_s);
        if (restart) begin
            frame_nxt  = 3'd0;
            div_nxt_s  = '0;
            done_nxt_s = 1'b0;
        end else if (tick && !(saturate && done_r)) begin
            // >= rather than == so a mid-sequence drop in div that leaves
            // the divider past the new limit still advances right away
            if (div_cnt_r >= (div - DIV_W'(1))) begin
                div_nxt_s = '0;
                if (at_last_s) begin
                    if (saturate) begin
                        frame_nxt  = frame_r;
                        done_nxt_s = 1'b1;
                    end else begin
                        frame_nxt  = 3'd0;
                        done_nxt_s = done_r;
                    end
                end else begin
                    frame_nxt = frame_r + 3'd1;
                    if (saturate && (({1'b0, frame_r} + 4'd1) == last_frame_s)) begin
                        done_nxt_s = 1'b1;
                    end else begin
                        done_nxt_s = done_r;
                    end
                end
            end else begin
                div_nxt_s = div_cnt_r + DIV_W'(1);
            end
        end else begin
            // no tick, or frozen on the saturated last frame
            frame_nxt  = frame_r;
            div_nxt_s  = div_cnt_r;
            done_nxt_s = done_r;
        end
    end

    // Counter state registers
    always_ff @(posedge VGA_clk or posedge rst) begin
        if (rst) begin
            div_cnt_r <= '0;
            frame_r   <= 3'd0;
            done_r    <= 1'b0;
        end else begin
            div_cnt_r <= div_nxt_s;
            frame_r   <= frame_nxt;
            done_r    <= done_nxt_s;
        end
    end

    assign frame = frame_r;
    assign done  = done_r;

endmodule

// File: rtl/sprite_anim_ctrl.sv
// ---------------------------------------------------------------------------
// sprite_anim_ctrl
// Chooses the player sprite animation and frame once per video frame so the
// sprite ROM address only changes during vblank.
//   VGA_clk, rst  : pixel clock, asynchronous active-high reset
//   frame_tick    : one-cycle pulse at start of vblank
//   game_state    : 1 = play, 2 = pause (hold), other = inactive (clear)
//   player_state  : 0 stand, 1 run, 2 jump, 3 hurt, other = stand
//   player_dir    : facing direction, latched into flip on play ticks
//   speed         : horizontal speed magnitude, selects slow/fast run rate
//   anim_sel      : current animation (FSM state)
//   frame_idx     : frame within the current animation
//   rom_base      : frame_idx * PLAYER_SIZE_X * PLAYER_SIZE_Y
//   flip          : latched player_dir
//   anim_done     : high while hurt is held on its last frame
// ---------------------------------------------------------------------------
module sprite_anim_ctrl
    import sprite_anim_ctrl_pkg::*;
#(
    parameter int PLAYER_SIZE_X = PLAYER_SIZE_X_DEF,
    parameter int PLAYER_SIZE_Y = PLAYER_SIZE_Y_DEF,
    parameter int RUN_FRAMES    = 4,
    parameter int JUMP_FRAMES   = 4,
    parameter int HURT_FRAMES   = 2,
    parameter int IDLE_DIV      = 32,
    parameter int RUN_DIV_SLOW  = 8,
    parameter int RUN_DIV_FAST  = 4,
    parameter int SPEED_THRESH  = 4
)(
    input  logic        VGA_clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic [3:0]  game_state,
    input  logic [3:0]  player_state,
    input  logic        player_dir,
    input  logic [7:0]  speed,
    output logic [1:0]  anim_sel,
    output logic [2:0]  frame_idx,
    output logic [15:0] rom_base,
    output logic        flip,
    output logic        anim_done
);

    localparam logic [15:0] FRAME_WORDS_C = 16'(PLAYER_SIZE_X * PLAYER_SIZE_Y);

    // Legacy-compatible FSM state constants (same codes as anim_sel)
    localparam logic [1:0] ST_STAND = ANIM_STAND;
    localparam logic [1:0] ST_RUN   = ANIM_RUN;
    localparam logic [1:0] ST_JUMP  = ANIM_JUMP;
    localparam logic [1:0] ST_HURT  = ANIM_HURT;

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [1:0]       req_s;
    logic             play_s;
    logic             inactive_s;
    logic             play_tick_s;
    logic             cnt_restart_s;
    logic             cnt_tick_s;
    logic [DIV_W-1:0] div_s;
    logic [3:0]       n_frames_s;
    logic             saturate_s;
    logic [2:0]       frame_s;
    logic [2:0]       frame_nxt_s;
    logic             done_s;
    logic [15:0]      rom_base_r;
    logic             flip_r;

    // Request decode, FSM next state and counter control
    always_comb begin
        req_s       = anim_request(player_state);
        play_s      = (game_state == GS_PLAY);
        inactive_s  = (game_state != GS_PLAY) && (game_state != GS_PAUSE);
        play_tick_s = frame_tick && play_s;
        // An animation change restarts the sequence; re-requesting the
        // current one (e.g. HURT while hurt) just keeps counting
        cnt_restart_s = inactive_s || (play_tick_s && (req_s != state_r));
        cnt_tick_s    = play_tick_s && (req_s == state_r);
        if (inactive_s) begin
            state_nxt_s = ST_STAND;
        end else if (play_tick_s) begin
            state_nxt_s = req_s;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Per-animation rate, length and end behaviour; speed is sampled live
    always_comb begin
        div_s      = DIV_W'(IDLE_DIV);
        n_frames_s = 4'd2;
        saturate_s = 1'b0;
        case (state_r)
            ST_STAND: begin
                div_s      = DIV_W'(IDLE_DIV);
                n_frames_s = 4'd2;
                saturate_s = 1'b0;
            end
            ST_RUN: begin
                if (speed >= 8'(SPEED_THRESH)) begin
                    div_s = DIV_W'(RUN_DIV_FAST);
                end else begin
                    div_s = DIV_W'(RUN_DIV_SLOW);
                end
                n_frames_s = 4'(RUN_FRAMES);
                saturate_s = 1'b0;
            end
            ST_JUMP: begin
                div_s      = DIV_W'(RUN_DIV_FAST);
                n_frames_s = 4'(JUMP_FRAMES);
                saturate_s = 1'b0;
            end
            ST_HURT: begin
                div_s      = DIV_W'(RUN_DIV_FAST);
                n_frames_s = 4'(HURT_FRAMES);
                saturate_s = 1'b1;
            end
            default: begin
                div_s      = DIV_W'(IDLE_DIV);
                n_frames_s = 4'd2;
                saturate_s = 1'b0;
            end
        endcase
    end

    anim_frame_counter u_frame_counter (
        .VGA_clk   (VGA_clk),
        .rst       (rst),
        .tick      (cnt_tick_s),
        .restart   (cnt_restart_s),
        .div       (div_s),
        .n_frames  (n_frames_s),
        .saturate  (saturate_s),
        .frame     (frame_s),
        .frame_nxt (frame_nxt_s),
        .done      (done_s)
    );

    // FSM state, flip latch and ROM base, all updated together with the frame
    always_ff @(posedge VGA_clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_STAND;
            flip_r     <= 1'b0;
            rom_base_r <= 16'd0;
        end else begin
            state_r    <= state_nxt_s;
            rom_base_r <= 16'(frame_nxt_s) * FRAME_WORDS_C;
            if (play_tick_s) begin
                flip_r <= player_dir;
            end else begin
                flip_r <= flip_r;
            end
        end
    end

    assign anim_sel  = state_r;
    assign frame_idx = frame_s;
    assign rom_base  = rom_base_r;
    assign flip      = flip_r;
    assign anim_done = done_s;

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sprite_anim_ctrl
// Self-checking bench for sprite_anim_ctrl. Each driven cycle feeds a
// behavioural model of the animation rules; the expected output word is
// queued and compared against the DUT one edge later.
// ---------------------------------------------------------------------------
module tb_sprite_anim_ctrl;

    logic        VGA_clk;
    logic        rst;
    logic        frame_tick;
    logic [3:0]  game_state;
    logic [3:0]  player_state;
    logic        player_dir;
    logic [7:0]  speed;
    logic [1:0]  anim_sel;
    logic [2:0]  frame_idx;
    logic [15:0] rom_base;
    logic        flip;
    logic        anim_done;

    sprite_anim_ctrl dut (
        .VGA_clk      (VGA_clk),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .game_state   (game_state),
        .player_state (player_state),
        .player_dir   (player_dir),
        .speed        (speed),
        .anim_sel     (anim_sel),
        .frame_idx    (frame_idx),
        .rom_base     (rom_base),
        .flip         (flip),
        .anim_done    (anim_done)
    );

    // 100 MHz-ish pixel clock
    initial VGA_clk = 1'b0;
    always #5 VGA_clk = ~VGA_clk;

    typedef struct packed {
        logic [1:0]  sel;
        logic [2:0]  frame;
        logic [15:0] base;
        logic        flp;
        logic        done;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state
    int   m_st;
    int   m_fr;
    int   m_dv;
    logic m_dn;
    logic m_flip;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_fr = 0; m_dv = 0; m_dn = 1'b0; m_flip = 1'b0;
    endtask

    // Applies the animation rules for one clock with the current inputs
    task automatic model_clock(input logic tick);
        int req;
        int d;
        int n;
        if (rst) begin
            model_reset();
        end else if (game_state != 4'd1 && game_state != 4'd2) begin
            m_st = 0; m_fr = 0; m_dv = 0; m_dn = 1'b0;
        end else if (game_state == 4'd1 && tick) begin
            m_flip = player_dir;
            req = (player_state <= 4'd3) ? int'(player_state) : 0;
            if (req != m_st) begin
                m_st = req; m_fr = 0; m_dv = 0; m_dn = 1'b0;
            end else begin
                case (m_st)
                    0: begin d = 32; n = 2; end
                    1: begin d = (speed >= 8'd4) ? 4 : 8; n = 4; end
                    2: begin d = 4; n = 4; end
                    default: begin d = 4; n = 2; end
                endcase
                if (m_st == 3 && m_dn) begin
                    // frozen on the last hurt frame
                end else if (m_dv + 1 >= d) begin
                    m_dv = 0;
                    if (m_st == 3) begin
                        if (m_fr < n - 1) m_fr = m_fr + 1;
                        if (m_fr == n - 1) m_dn = 1'b1;
                    end else begin
                        m_fr = (m_fr + 1) % n;
                    end
                end else begin
                    m_dv = m_dv + 1;
                end
            end
        end
    endtask

    // Drives one cycle, queues the model's expectation, compares after the edge
    task automatic step(input logic tick);
        exp_t e;
        exp_t got;
        frame_tick = tick;
        model_clock(tick);
        e.sel   = 2'(m_st);
        e.frame = 3'(m_fr);
        e.base  = 16'(m_fr * 1554);
        e.flp   = m_flip;
        e.done  = m_dn;
        exp_q.push_back(e);
        @(posedge VGA_clk);
        #1;
        frame_tick = 1'b0;
        got = exp_q.pop_front();
        check("anim_sel",  32'(anim_sel),  32'(got.sel));
        check("frame_idx", 32'(frame_idx), 32'(got.frame));
        check("rom_base",  32'(rom_base),  32'(got.base));
        check("flip",      32'(flip),      32'(got.flp));
        check("anim_done", 32'(anim_done), 32'(got.done));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1);
    endtask

    initial begin
        rst = 1'b1; frame_tick = 1'b0; game_state = 4'd1; player_state = 4'd0;
        player_dir = 1'b0; speed = 8'd0;
        model_reset();
        #2;
        check("rst_sel_async",  32'(anim_sel), 32'd0);
        check("rst_base_async", 32'(rom_base), 32'd0);
        step(1'b1); step(1'b0); step(1'b1);
        rst = 1'b0;

        // Idle blink: 32 ticks per frame, then wrap
        ticks(40);
        check("idle_frame1", 32'(frame_idx), 32'd1);
        check("idle_base1",  32'(rom_base),  32'd1554);
        ticks(24);

        // Slow run, with idle gaps between some ticks
        player_state = 4'd1; speed = 8'd2;
        step(1'b1);
        for (int i = 0; i < 24; i++) begin
            step(1'b1);
            if (i % 5 == 0) step(1'b0);
        end
        check("run_frame3", 32'(frame_idx), 32'd3);
        check("run_base3",  32'(rom_base),  32'd4662);
        ticks(15);
        // Fast run, then crossings exactly around the threshold
        speed = 8'd10; ticks(12);
        speed = 8'd3;  ticks(6);
        speed = 8'd4;  ticks(3);
        speed = 8'd3;  ticks(9);

        // Pause mid-run, then resume
        speed = 8'd2;
        while (m_fr != 2 || m_dv != 3) step(1'b1);
        game_state = 4'd2;
        for (int i = 0; i < 50; i++) begin
            player_state = 4'(i % 4); player_dir = i[0];
            step(1'b1);
        end
        check("pause_frame", 32'(frame_idx), 32'd2);
        player_state = 4'd1; player_dir = 1'b0; game_state = 4'd1;
        ticks(10);

        // Hurt saturates on its last frame and ignores re-requests
        player_state = 4'd3;
        ticks(20);
        check("hurt_done",  32'(anim_done), 32'd1);
        check("hurt_frame", 32'(frame_idx), 32'd1);
        player_state = 4'd3; ticks(6);
        player_state = 4'd0; ticks(2);
        player_state = 4'd3; ticks(6);

        // Jump to frame 3, then go inactive with no tick
        player_state = 4'd2; player_dir = 1'b1;
        ticks(13);
        check("jump_frame3", 32'(frame_idx), 32'd3);
        game_state = 4'd3;
        step(1'b0);
        check("inact_sel",  32'(anim_sel), 32'd0);
        check("inact_base", 32'(rom_base), 32'd0);
        check("inact_flip", 32'(flip),     32'd1);
        step(1'b1); step(1'b0);
        game_state = 4'd1;

        // flip only follows player_dir on ticks
        player_state = 4'd1; speed = 8'd5;
        ticks(3);
        for (int i = 0; i < 6; i++) begin
            player_dir = ~player_dir; step(1'b0);
            player_dir = ~player_dir; step(1'b0);
            player_dir = ~player_dir; step(1'b1);
        end

        // Asynchronous reset mid-run
        ticks(5);
        rst = 1'b1;
        #2;
        check("midrst_sel",   32'(anim_sel),  32'd0);
        check("midrst_frame", 32'(frame_idx), 32'd0);
        check("midrst_base",  32'(rom_base),  32'd0);
        check("midrst_flip",  32'(flip),      32'd0);
        model_reset();
        @(negedge VGA_clk);
        step(1'b1);
        rst = 1'b0;
        ticks(6);

        // Random mix of inputs
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) game_state = 4'($urandom_range(0, 5));
            else if (game_state != 4'd1 && $urandom_range(0, 3) == 0) game_state = 4'd1;
            if ($urandom_range(0, 19) == 0) player_state = 4'($urandom_range(0, 5));
            if ($urandom_range(0, 9) == 0) speed = 8'($urandom_range(0, 8));
            player_dir = 1'($urandom_range(0, 1));
            step(1'($urandom_range(0, 2) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
